// File: rtl/uart_pkg.sv
// Shared UART definitions: default bit period, payload width, FSM state encoding and parity helper.
package uart_pkg;

  localparam int CLKS_PER_BIT_DEF = 434;
  localparam int DATA_BITS        = 8;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;

  function automatic logic even_parity(input logic [DATA_BITS-1:0] data_byte);
    return ^data_byte;
  endfunction

endpackage

// File: rtl/uart_bit_timer.sv
// Bit-period counter: o_bit_end is a registered strobe high while the count sits at CLKS_PER_BIT-1.
// i_clr holds the count at 0; with i_clr low the count free-runs and wraps at the terminal value.
module uart_bit_timer #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_bit_end
);

  localparam int W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] r_clk_c;
  logic [W-1:0] w_clk_c_nxt;
  logic         r_bit_end;

  always_comb begin
    w_clk_c_nxt = r_clk_c + 1'b1;
    if (i_clr || (r_clk_c == LAST)) begin
      w_clk_c_nxt = '0;
    end
  end

  // Strobe is computed from the next count so it lines up with clk_c==LAST.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_clk_c   <= '0;
      r_bit_end <= 1'b0;
    end else begin
      r_clk_c   <= w_clk_c_nxt;
      r_bit_end <= (w_clk_c_nxt == LAST);
    end
  end

  assign o_bit_end = r_bit_end;

endmodule

// File: rtl/uart_tx_rtl_1.sv
// 8N1 UART transmitter, LSB first, one-entry holding buffer; tx falls 1 clk after the handshake.
// o_tx_ready is low while the buffer is full. Define UART_TX_PARITY_EN to add an even parity bit.
module uart_tx_rtl_1
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [DATA_BITS-1:0] i_tx_data,
  input  logic                 i_tx_valid,
  output logic                 o_tx_ready,
  output logic                 o_tx,
  output logic                 o_tx_busy,
  output logic                 o_tx_done
);

  localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

  uart_tx_state_t       r_state;
  logic                 r_hold_full;
  logic [DATA_BITS-1:0] r_hold_data;
  logic [DATA_BITS-1:0] r_shift;
  logic [2:0]           r_bit_c;
  logic                 r_tx;
  logic                 r_busy;
  logic                 r_done;
  logic                 w_bit_end;
  logic                 w_timer_clr;
`ifdef UART_TX_PARITY_EN
  logic                 r_parity;
`endif

  assign w_timer_clr = (r_state == IDLE);

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (w_timer_clr),
    .o_bit_end (w_bit_end)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_hold_full <= 1'b0;
      r_hold_data <= '0;
      r_shift     <= '0;
      r_bit_c     <= '0;
      r_tx        <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      r_parity    <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      if (i_tx_valid && !r_hold_full) begin
        r_hold_full <= 1'b1;
        r_hold_data <= i_tx_data;
      end
      case (r_state)
        IDLE: begin
          r_tx <= 1'b1;
          if (r_hold_full) begin
            r_shift     <= r_hold_data;
            r_hold_full <= 1'b0;
            r_state     <= START;
            r_tx        <= 1'b0;
            r_busy      <= 1'b1;
`ifdef UART_TX_PARITY_EN
            r_parity    <= even_parity(r_hold_data);
`endif
          end
        end
        START: begin
          if (w_bit_end) begin
            r_state <= DATA;
            r_bit_c <= '0;
            r_tx    <= r_shift[0];
          end
        end
        DATA: begin
          if (w_bit_end) begin
            if (r_bit_c == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              r_state <= PARITY;
              r_tx    <= r_parity;
`else
              r_state <= STOP;
              r_tx    <= 1'b1;
`endif
            end else begin
              r_bit_c <= r_bit_c + 1'b1;
              r_shift <= r_shift >> 1;
              r_tx    <= r_shift[1];
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (w_bit_end) begin
            r_state <= STOP;
            r_tx    <= 1'b1;
          end
        end
`endif
        STOP: begin
          if (w_bit_end) begin
            r_done <= 1'b1;
            // A pending byte starts immediately so frames abut with no idle bit.
            if (r_hold_full) begin
              r_shift     <= r_hold_data;
              r_hold_full <= 1'b0;
              r_state     <= START;
              r_tx        <= 1'b0;
`ifdef UART_TX_PARITY_EN
              r_parity    <= even_parity(r_hold_data);
`endif
            end else begin
              r_state <= IDLE;
              r_tx    <= 1'b1;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign o_tx_ready = !r_hold_full;
  assign o_tx       = r_tx;
  assign o_tx_busy  = r_busy;
  assign o_tx_done  = r_done;

endmodule

// File: doc/uart_tx_rtl_1.md
Name: uart_tx_rtl_1

Overview:
- 8N1 UART transmitter: serialises bytes onto `tx`, LSB first, one start bit, one stop bit.
- Bit period is CLKS_PER_BIT clocks (434 at 100 MHz, about 230400 baud). This pairs with uart_rx_rtl_1 for loopback.
- A one-entry holding buffer behind a valid/ready handshake lets frames go out back to back with no idle gap.

Parameters:
- CLKS_PER_BIT, 434: clocks per serial bit; legal range >= 2.
- DATA_BITS, 8: payload bits per frame; fixed at 8 for this revision.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- tx_data  in  8  byte to send; sampled on a handshake.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  holding buffer empty; equals !hold_full (combinational from a register).
- tx  out  1  serial line, registered, idles high.
- tx_busy  out  1  high while the FSM is not in IDLE.
- tx_done  out  1  one-cycle pulse at the end of each stop bit.

Behaviour:
- Reset values: tx=1, tx_busy=0, tx_done=0, tx_ready=1. Holding buffer emptied, clk_c=0, bit_c=0, state IDLE.
- Handshake:
  - A byte is accepted on a rising edge where tx_valid && tx_ready.
  - The byte is stored in hold_data and hold_full is set.
  - tx_valid may stay high; no byte is accepted while hold_full=1.
- FSM states: IDLE, START, DATA, STOP (plus PARITY with the optional feature).
- IDLE:
  - tx=1.
  - If hold_full=1: load shift_reg<=hold_data, clear hold_full, set clk_c=0, go to START.
  - tx goes low on the edge after the handshake edge, i.e. a latency of 1 clock.
- Bit timing:
  - Each of START, DATA and STOP lasts exactly CLKS_PER_BIT clocks.
  - clk_c counts 0..CLKS_PER_BIT-1. Leave the state or advance the bit when clk_c==CLKS_PER_BIT-1, then clk_c wraps to 0.
- START: tx=0. Then go to DATA with bit_c=0.
- DATA:
  - tx=shift_reg[0]; the register shifts right at each bit boundary.
  - bit_c counts 0..7. After bit 7, go to STOP.
- STOP: tx=1. At the end of the stop bit, tx_done=1 for one cycle, then:
  - If hold_full=1: load the next byte, clear hold_full, go straight to START. No idle gap; the frame pitch is exactly 10*CLKS_PER_BIT.
  - Otherwise go to IDLE.
- Buffer refill: a new handshake during any frame state refills the buffer. tx_ready falls the cycle after acceptance.
- Simultaneous events: on the cycle the FSM empties the buffer, tx_ready is still 0, so a new byte cannot be accepted that cycle. It is accepted the next cycle.
- Reset mid-frame:
  - tx returns to 1 on the next edge and the FSM goes to IDLE.
  - The buffered byte is discarded and no tx_done is emitted.
- Counter widths: clk_c is $clog2(CLKS_PER_BIT) bits; bit_c is 3 bits. Neither counter ever exceeds its terminal count.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx = ^data_byte (even parity), lasting CLKS_PER_BIT clocks.
  - The parity is computed from the byte at load time.
  - Frame and pitch become 11*CLKS_PER_BIT.
- Undefined: no PARITY state and no parity logic; 8N1 frames of 10*CLKS_PER_BIT.

Decomposition:
- Package uart_pkg holds:
  - localparam CLKS_PER_BIT_DEF=434 and DATA_BITS=8;
  - typedef enum logic [2:0] uart_tx_state_t {IDLE, START, DATA, PARITY, STOP}, shared with the receiver side;
  - function even_parity(byte).
- Sub-module uart_bit_timer: clk_c counter with a clear input and a registered bit_end strobe at CLKS_PER_BIT-1. Reusable by uart_rx_rtl_1.

Test Plan:
- Reset check: hold rst for 2 cycles with tx_valid=1 -> tx=1, tx_busy=0, tx_done=0, tx_ready=1 throughout; no byte accepted.
- Single byte: send 8'd66 (0x42) -> tx falls 1 clk after the handshake. Bits 0,1,0,0,0,0,1,0, each 434 clks, then stop=1. tx_done pulses once at 4340 clks after the fall.
- Back to back: send 8'd66, then 8'd111 while busy -> the second start bit begins on the clock after the first stop ends. Data 1,1,1,1,0,1,1,0; two tx_done pulses exactly 4340 clks apart.
- Reset mid-frame: reset after bit 2 of 0x42 -> tx=1 the next clk, no tx_done. A fresh 0x42 afterwards transmits a complete, correct frame.
- Loopback: connect tx to uart_rx_rtl_1.rx, send 66 then 111 -> the receiver reports rx_data=66, then 111, each with one rx_done.
- UART_TX_PARITY_EN defined: send 0x42 -> parity bit 0 after bit 7, frame length 4774 clks. Send 0x6F -> parity bit 0; send 0x07 -> parity bit 1.
